uvc_payload_ctrl: RTL and testbench

- Sequences the test-pattern frame source into UVC bulk/iso payloads.
- Paces frame starts from USB microframe SOFs.
- Pulls pixel bytes from the source with a valid/ready handshake and prepends a 12-byte UVC payload header to every payload, carrying FID/EOF/PTS/SCR.
- Sits between the frame source and the USB TX FIFO. Replaces ad-hoc header/FID handling inside the source.

---
 rtl/uvc_payload_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_uvc_payload_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvc_payload_ctrl.sv
// uvc_payload_ctrl: paces test-pattern frames from USB microframe SOFs and
// turns the pixel byte stream into UVC payloads. Each payload is a 12-byte
// header (FID/EOF/PTS/SCR) followed by up to PAYLOAD_SIZE-HEADER_LEN bytes.
//
// Handshake: a source byte moves on a rising CLK_I when SRC_VALID_I and
// SRC_READY_O are both high. SRC_READY_O never depends on SRC_VALID_I. The
// byte appears on DATA_O with a one-cycle DVAL_O strobe in the next cycle.
module uvc_payload_ctrl #(
    parameter int FRAME_BYTES  = 307200,
    parameter int PAYLOAD_SIZE = 1024,
    parameter int HEADER_LEN   = 12,
    parameter int SOF_PERIOD   = 104
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        SOF_I,
    input  logic [10:0] SOF_NUM_I,
    input  logic [31:0] PTS_I,
    input  logic        FIFO_AFULL_I,
    input  logic        FIFO_EMPTY_I,
    input  logic [7:0]  SRC_DATA_I,
    input  logic        SRC_VALID_I,
    output logic        SRC_READY_O,
    output logic        FRAME_START_O,
    output logic [7:0]  DATA_O,
    output logic        DVAL_O,
    output logic        FID_O,
    output logic        BUSY_O,
    output logic [7:0]  SKIP_CNT_O,
    output logic [1:0]  DBG_STATE_O
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [23:0] FRAME_LEN = 24'(FRAME_BYTES);
    localparam logic [23:0] PAY_MAX   = 24'(PAYLOAD_SIZE - HEADER_LEN);
    localparam logic [10:0] PAY_LAST  = 11'(PAYLOAD_SIZE - HEADER_LEN - 1);
    localparam logic [3:0]  HDR_LAST  = 4'(HEADER_LEN - 1);
    localparam logic [15:0] SOF_LAST  = 16'(SOF_PERIOD - 1);

    state_t      state;
    state_t      state_nxt;
    logic        sof_d1;
    logic        sof_rise_r;
    logic [15:0] sof_cnt;
    logic [23:0] remain;
    logic [23:0] remain_nxt;
    logic [10:0] pay_cnt;
    logic [3:0]  hdr_idx;
    logic [31:0] pts_r;
    logic [10:0] sofn_r;
    logic        eof_r;
    logic        fid;
    logic [7:0]  skip_cnt;
    logic [7:0]  data_r;
    logic        dval_r;
    logic        frame_start_r;
    logic [7:0]  hdr_byte;

    logic slot;
    logic start_ok;
    logic skip;
    logic src_ready;
    logic xfer;
    logic hdr_emit;
    logic hdr_entry;

    // Slot and handshake qualifiers, all from registered state plus inputs
    always_comb begin
        slot      = sof_rise_r && (sof_cnt == 16'd0);
        start_ok  = slot && (state == ST_IDLE) && FIFO_EMPTY_I;
        skip      = slot && !start_ok;
        src_ready = (state == ST_PAY) && !FIFO_AFULL_I;
        xfer      = src_ready && SRC_VALID_I;
        hdr_emit  = (state == ST_HDR) && !FIFO_AFULL_I;
    end

    // Next state and next remaining-byte count
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt  = ST_HDR;
                    remain_nxt = FRAME_LEN;
                end
            end
            ST_HDR: begin
                if (hdr_emit && (hdr_idx == HDR_LAST)) begin
                    state_nxt = ST_PAY;
                end
            end
            ST_PAY: begin
                if (xfer) begin
                    remain_nxt = remain - 24'd1;
                    if (remain == 24'd1) begin
                        state_nxt = ST_DONE;
                    end else if (pay_cnt == PAY_LAST) begin
                        state_nxt = ST_HDR;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Header fields are captured on the cycle that enters HDR
        hdr_entry = (state_nxt == ST_HDR) && (state != ST_HDR);
    end

    // Header byte selected by the current header index
    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            4'd0:  hdr_byte = 8'h0C;
            4'd1:  hdr_byte = 8'h8C | {6'b0, eof_r, fid};
            4'd2:  hdr_byte = pts_r[7:0];
            4'd3:  hdr_byte = pts_r[15:8];
            4'd4:  hdr_byte = pts_r[23:16];
            4'd5:  hdr_byte = pts_r[31:24];
            4'd6:  hdr_byte = pts_r[7:0];
            4'd7:  hdr_byte = pts_r[15:8];
            4'd8:  hdr_byte = pts_r[23:16];
            4'd9:  hdr_byte = pts_r[31:24];
            4'd10: hdr_byte = sofn_r[7:0];
            4'd11: hdr_byte = {5'b0, sofn_r[10:8]};
            default: hdr_byte = 8'h00;
        endcase
    end

    // SOF edge detect, microframe counter and skip counter
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            sof_d1     <= 1'b0;
            sof_rise_r <= 1'b0;
            sof_cnt    <= 16'd0;
            skip_cnt   <= 8'd0;
        end else begin
            sof_d1     <= SOF_I;
            sof_rise_r <= SOF_I & ~sof_d1;
            if (sof_rise_r) begin
                sof_cnt <= (sof_cnt == SOF_LAST) ? 16'd0 : sof_cnt + 16'd1;
            end
            if (skip && (skip_cnt != 8'hFF)) begin
                skip_cnt <= skip_cnt + 8'd1;
            end
        end
    end

    // FSM state register, frame byte budget and frame ID
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state  <= ST_IDLE;
            remain <= 24'd0;
            fid    <= 1'b0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
            if (state == ST_DONE) begin
                fid <= ~fid;
            end
        end
    end

    // Header field capture and header/payload position counters
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            pts_r   <= 32'd0;
            sofn_r  <= 11'd0;
            eof_r   <= 1'b0;
            hdr_idx <= 4'd0;
            pay_cnt <= 11'd0;
        end else begin
            if (hdr_entry) begin
                pts_r   <= PTS_I;
                sofn_r  <= SOF_NUM_I;
                eof_r   <= (remain_nxt <= PAY_MAX);
                hdr_idx <= 4'd0;
            end else if (hdr_emit) begin
                hdr_idx <= (hdr_idx == HDR_LAST) ? 4'd0 : hdr_idx + 4'd1;
            end
            if (hdr_emit && (hdr_idx == HDR_LAST)) begin
                pay_cnt <= 11'd0;
            end else if (xfer) begin
                pay_cnt <= pay_cnt + 11'd1;
            end
        end
    end

    // Registered output byte, write strobe and frame-start pulse
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            data_r        <= 8'd0;
            dval_r        <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            dval_r        <= 1'b0;
            frame_start_r <= start_ok;
            if (hdr_emit) begin
                data_r <= hdr_byte;
                dval_r <= 1'b1;
            end else if (xfer) begin
                data_r <= SRC_DATA_I;
                dval_r <= 1'b1;
            end
        end
    end

    assign SRC_READY_O   = src_ready;
    assign FRAME_START_O = frame_start_r;
    assign DATA_O        = data_r;
    assign DVAL_O        = dval_r;
    assign FID_O         = fid;
    assign BUSY_O        = (state != ST_IDLE);
    assign SKIP_CNT_O    = skip_cnt;
    assign DBG_STATE_O   = state;

endmodule

// File: tb/tb_uvc_payload_ctrl.sv
// tb_uvc_payload_ctrl: drives SOF pulses, a byte source and FIFO flags into
// uvc_payload_ctrl and compares the DVAL_O byte stream with a frame model
// built from the payload/header rules.
module tb_uvc_payload_ctrl;

    localparam int FB = 40;
    localparam int PS = 24;
    localparam int HL = 12;
    localparam int SP = 4;
    localparam int PM = PS - HL;

    // Clock and reset
    logic        clk = 1'b0;
    logic        RST_I = 1'b1;
    logic        SOF_I = 1'b0;
    logic [10:0] SOF_NUM_I = '0;
    logic [31:0] PTS_I = '0;
    logic        FIFO_AFULL_I = 1'b0;
    logic        FIFO_EMPTY_I = 1'b1;
    logic [7:0]  SRC_DATA_I = '0;
    logic        SRC_VALID_I = 1'b0;
    logic        SRC_READY_O;
    logic        FRAME_START_O;
    logic [7:0]  DATA_O;
    logic        DVAL_O;
    logic        FID_O;
    logic        BUSY_O;
    logic [7:0]  SKIP_CNT_O;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    uvc_payload_ctrl #(
        .FRAME_BYTES (FB),
        .PAYLOAD_SIZE(PS),
        .HEADER_LEN  (HL),
        .SOF_PERIOD  (SP)
    ) dut (
        .CLK_I        (clk),
        .RST_I        (RST_I),
        .SOF_I        (SOF_I),
        .SOF_NUM_I    (SOF_NUM_I),
        .PTS_I        (PTS_I),
        .FIFO_AFULL_I (FIFO_AFULL_I),
        .FIFO_EMPTY_I (FIFO_EMPTY_I),
        .SRC_DATA_I   (SRC_DATA_I),
        .SRC_VALID_I  (SRC_VALID_I),
        .SRC_READY_O  (SRC_READY_O),
        .FRAME_START_O(FRAME_START_O),
        .DATA_O       (DATA_O),
        .DVAL_O       (DVAL_O),
        .FID_O        (FID_O),
        .BUSY_O       (BUSY_O),
        .SKIP_CNT_O   (SKIP_CNT_O),
        .DBG_STATE_O  (dbg_state)
    );

    // Scoreboard and reference model state
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] src_bytes [FB];
    int         total = 0;
    int         bad = 0;
    int         src_idx = 0;
    int         fs_cnt = 0;
    int         sof_n = 0;
    int         skip_m = 0;
    bit         fid_m = 1'b0;
    bit         rnd = 1'b0;
    bit         seen_hs = 1'b0;
    bit         stall_en = 1'b0;
    int         stall_idx = 0;
    int         stall_left = 0;
    int         stall_pos [2] = '{6, 40};
    logic [7:0] hdr_ref [10] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44, 8'h33,
                                 8'h22, 8'h11, 8'hA5, 8'h05};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected byte stream of one frame: header + chunk, last chunk may be short
    function automatic void build_exp(input bit f, input logic [31:0] pts, input logic [10:0] sn);
        int rem;
        int pos;
        int n;
        logic [7:0] b1;
        exp_q.delete();
        rem = FB;
        pos = 0;
        while (rem > 0) begin
            n  = (rem < PM) ? rem : PM;
            b1 = 8'h8C | ((rem <= PM) ? 8'h02 : 8'h00) | {7'b0, f};
            exp_q.push_back(8'h0C);
            exp_q.push_back(b1);
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < 4; k++) begin
                    exp_q.push_back(8'((pts >> (8 * k)) & 32'hFF));
                end
            end
            exp_q.push_back(sn[7:0]);
            exp_q.push_back({5'b0, sn[10:8]});
            for (int k = 0; k < n; k++) begin
                exp_q.push_back(src_bytes[pos + k]);
            end
            pos += n;
            rem -= n;
        end
    endfunction

    // One clock: drive inputs at negedge, observe outputs at the next negedge
    task automatic cycle();
        bit hs;
        bit af;
        if (stall_left > 0) begin
            af = 1'b1;
            stall_left--;
        end else if (stall_en && stall_idx < 2 && got_q.size() == stall_pos[stall_idx]) begin
            af = 1'b1;
            stall_left = 4;
            stall_idx++;
        end else if (rnd) begin
            af = ($urandom_range(0, 4) == 0);
        end else begin
            af = 1'b0;
        end
        FIFO_AFULL_I = af;
        SRC_VALID_I  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        SRC_DATA_I   = (src_idx < FB) ? src_bytes[src_idx] : 8'($urandom);
        #1;
        hs = SRC_VALID_I && SRC_READY_O;
        if (af) check("ready_in_stall", {31'b0, SRC_READY_O}, 32'd0);
        @(posedge clk);
        if (hs) begin
            src_idx++;
            seen_hs = 1'b1;
        end
        @(negedge clk);
        if (af) check("dval_in_stall", {31'b0, DVAL_O}, 32'd0);
        if (DVAL_O === 1'b1) got_q.push_back(DATA_O);
        if (FRAME_START_O === 1'b1) begin
            fs_cnt++;
            src_idx = 0;
        end
    endtask

    task automatic sof_pulse();
        SOF_I = 1'b1;
        cycle();
        SOF_I = 1'b0;
        cycle();
        sof_n++;
    endtask

    // Emit SOF pulses up to and including the next frame slot
    task automatic goto_slot();
        while (sof_n % SP != 0) sof_pulse();
        sof_pulse();
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic run_frame(input bit busy_slot);
        int fs0;
        int budget;
        build_exp(fid_m, PTS_I, SOF_NUM_I);
        got_q.delete();
        fs0 = fs_cnt;
        goto_slot();
        check("busy_after_slot", {31'b0, BUSY_O}, 32'd1);
        check("fid_during", {31'b0, FID_O}, {31'b0, fid_m});
        if (busy_slot) begin
            goto_slot();
            skip_m = sat_inc(skip_m);
        end
        budget = 0;
        while (BUSY_O === 1'b1 && budget < 5000) begin
            cycle();
            budget++;
        end
        check("frame_timeout", {31'b0, budget < 5000}, 32'd1);
        fid_m = ~fid_m;
        check("frame_starts", fs_cnt - fs0, 32'd1);
        check("stream_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("byte%0d", i), {24'b0, got_q[i]}, {24'b0, exp_q[i]});
        end
        check("fid_after", {31'b0, FID_O}, {31'b0, fid_m});
        check("skip_cnt", {24'b0, SKIP_CNT_O}, skip_m);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dval"}, {31'b0, DVAL_O}, 32'd0);
        check({tag, "_data"}, {24'b0, DATA_O}, 32'd0);
        check({tag, "_fstart"}, {31'b0, FRAME_START_O}, 32'd0);
        check({tag, "_ready"}, {31'b0, SRC_READY_O}, 32'd0);
        check({tag, "_busy"}, {31'b0, BUSY_O}, 32'd0);
        check({tag, "_fid"}, {31'b0, FID_O}, 32'd0);
        check({tag, "_skip"}, {24'b0, SKIP_CNT_O}, 32'd0);
    endtask

    initial begin
        int budget;
        int fs0;
        @(negedge clk);
        RST_I = 1'b1;
        repeat (3) cycle();
        check_idle_outputs("reset");
        RST_I = 1'b0;
        cycle();

        // Frame A: bytes 0..39, fixed PTS/SOF number, no back-pressure
        for (int i = 0; i < FB; i++) src_bytes[i] = 8'(i);
        PTS_I     = 32'h11223344;
        SOF_NUM_I = 11'h5A5;
        run_frame(1'b0);
        check("a_pulses", got_q.size(), 32'd88);
        if (got_q.size() > 73) check("a_hdr4_b1", {24'b0, got_q[73]}, 32'h8E);
        if (got_q.size() > 11) begin
            for (int i = 0; i < 10; i++) check($sformatf("a_hdr_b%0d", i + 2), {24'b0, got_q[i + 2]}, {24'b0, hdr_ref[i]});
        end

        // Frame B: stalls at header byte 6 and in the middle of payload 2
        PTS_I     = $urandom;
        SOF_NUM_I = 11'($urandom);
        stall_en  = 1'b1;
        stall_idx = 0;
        run_frame(1'b0);
        stall_en  = 1'b0;
        if (got_q.size() > 1) check("b_hdr1_b1", {24'b0, got_q[1]}, 32'h8D);

        // Frames C..E: random source gaps and FIFO back-pressure
        rnd = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FB; i++) src_bytes[i] = 8'($urandom);
            PTS_I     = $urandom;
            SOF_NUM_I = 11'($urandom);
            run_frame(f == 0);
        end
        rnd = 1'b0;

        // Slot with a non-empty FIFO is a skip
        FIFO_EMPTY_I = 1'b0;
        fs0 = fs_cnt;
        goto_slot();
        skip_m = sat_inc(skip_m);
        repeat (4) cycle();
        check("nonempty_nostart", fs_cnt - fs0, 32'd0);
        check("nonempty_idle", {31'b0, BUSY_O}, 32'd0);
        check("nonempty_skip", {24'b0, SKIP_CNT_O}, skip_m);

        // 300 skipped slots saturate the counter
        for (int s = 0; s < 300; s++) begin
            goto_slot();
            skip_m = sat_inc(skip_m);
            if (s == 100) check("skip_mid", {24'b0, SKIP_CNT_O}, skip_m);
        end
        cycle();
        check("skip_sat", {24'b0, SKIP_CNT_O}, 32'd255);
        check("skip_nostart", fs_cnt - fs0, 32'd0);
        FIFO_EMPTY_I = 1'b1;
        check("fid_before_rst", {31'b0, FID_O}, {31'b0, fid_m});

        // Reset while payload bytes are flowing
        for (int i = 0; i < FB; i++) src_bytes[i] = 8'($urandom);
        got_q.delete();
        goto_slot();
        seen_hs = 1'b0;
        budget  = 0;
        while (!seen_hs && budget < 100) begin
            cycle();
            budget++;
        end
        check("reach_pay", {31'b0, seen_hs}, 32'd1);
        repeat (3) cycle();
        RST_I = 1'b1;
        cycle();
        RST_I = 1'b0;
        check_idle_outputs("midrst");
        fid_m  = 1'b0;
        sof_n  = 0;
        skip_m = 0;
        cycle();

        // First frame after reset starts with FID 0
        PTS_I     = $urandom;
        SOF_NUM_I = 11'($urandom);
        run_frame(1'b0);
        if (got_q.size() > 1) check("post_rst_b1", {24'b0, got_q[1]}, 32'h8C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
